// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, code constants, default timing and the ITU Morse table.
package morse_pkg;
  typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, WGAP} state_t;
  localparam logic [5:0] CODE_WORDSPACE = 6'd36;
  localparam logic [5:0] CODE_MAX_LEGAL = 6'd36;
  localparam int DEF_DASH_UNITS = 3;
  localparam int DEF_LGAP_UNITS = 3;
  localparam int DEF_WGAP_UNITS = 7;
  // {len[2:0], pattern[4:0]}; pattern is left-aligned so the first element sits in bit 4, 1 = dash
  localparam logic [7:0] MORSE_TABLE [36] = '{
    8'b010_01000, 8'b100_10000, 8'b100_10100, 8'b011_10000, 8'b001_00000, 8'b100_00100,
    8'b011_11000, 8'b100_00000, 8'b010_00000, 8'b100_01110, 8'b011_10100, 8'b100_01000,
    8'b010_11000, 8'b010_10000, 8'b011_11100, 8'b100_01100, 8'b100_11010, 8'b011_01000,
    8'b011_00000, 8'b001_10000, 8'b011_00100, 8'b100_00010, 8'b011_01100, 8'b100_10010,
    8'b100_10110, 8'b100_11000,
    8'b101_11111, 8'b101_01111, 8'b101_00111, 8'b101_00011, 8'b101_00001,
    8'b101_00000, 8'b101_10000, 8'b101_11000, 8'b101_11100, 8'b101_11110
  };
endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational character code to Morse element count and pattern.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output logic [2:0] len,
  output logic [4:0] pattern,
  output logic       legal
);
  logic [7:0] entry;
  always_comb begin
    entry = char_code < CODE_WORDSPACE ? MORSE_TABLE[char_code] : 8'd0;
    legal = char_code <= CODE_MAX_LEGAL;
  end
  assign {len, pattern} = entry;
endmodule

// File: rtl/morse_sender.sv
// morse_sender: keys out one character at a time as Morse marks and gaps paced by unit ticks.
module morse_sender
  import morse_pkg::*;
#(
  parameter int DASH_UNITS = DEF_DASH_UNITS,
  parameter int LGAP_UNITS = DEF_LGAP_UNITS,
  parameter int WGAP_UNITS = DEF_WGAP_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       char_done,
  output logic       err
);
  state_t state;
  logic [2:0] cnt, left, len, limit;
  logic [4:0] pat, rom_pat;
  logic legal, expire;
  morse_rom u_rom (.char_code(char_code), .len(len), .pattern(rom_pat), .legal(legal));
  always_comb begin
    limit = state == MARK ? (pat[4] ? 3'(DASH_UNITS) : 3'd1) :
            state == LGAP ? 3'(LGAP_UNITS) :
            state == WGAP ? 3'(WGAP_UNITS) : 3'd1;
    expire = tick && cnt == limit - 3'd1;
  end
  assign char_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      left <= '0;
      pat <= '0;
      key_out <= 1'b0;
      char_done <= 1'b0;
      err <= 1'b0;
    end else begin
      char_done <= 1'b0;
      err <= 1'b0;
      if (state == IDLE) begin
        if (char_valid && !legal) err <= 1'b1;
        else if (char_valid && char_code == CODE_WORDSPACE) state <= WGAP;
        else if (char_valid) begin
          state <= MARK;
          key_out <= 1'b1;
          pat <= rom_pat;
          left <= len;
        end
      end else if (expire) begin
        cnt <= '0;
        case (state)
          MARK: begin
            key_out <= 1'b0;
            state <= left > 3'd1 ? SPACE : LGAP;
            pat <= pat << 1;
            left <= left - 3'd1;
          end
          SPACE: begin
            state <= MARK;
            key_out <= 1'b1;
          end
          default: begin
            state <= IDLE;
            char_done <= 1'b1;
          end
        endcase
      end else if (tick) cnt <= cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_morse_sender.sv
// tb_morse_sender: random and directed characters checked per unit tick against a dot/dash string model.
module tb_morse_sender;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, char_valid = 1'b0;
  logic [5:0] char_code = '0;
  logic char_ready, key_out, busy, char_done, err;
  int vectors = 0, miscompares = 0;
  string sb[$];
  string got = "";
  string morse_tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--",
    "-..-", "-.--", "--..", "-----", ".----", "..---", "...--", "....-", ".....", "-....",
    "--...", "---..", "----."};

  always #5 clk = ~clk;

  morse_sender dut (.clk(clk), .rst(rst), .tick(tick), .char_valid(char_valid), .char_code(char_code),
    .char_ready(char_ready), .key_out(key_out), .busy(busy), .char_done(char_done), .err(err));

  // expected key level for every unit tick of a character, trailing gap included
  function automatic string model(int code);
    string s, r;
    r = "";
    if (code > 36) return "ERR";
    if (code == 36) begin
      for (int k = 0; k < 7; k++) r = {r, "0"};
      return r;
    end
    s = morse_tbl[code];
    for (int i = 0; i < s.len(); i++) begin
      for (int k = 0; k < (s[i] == 8'h2d ? 3 : 1); k++) r = {r, "1"};
      if (i < s.len() - 1) r = {r, "0"};
    end
    for (int k = 0; k < 3; k++) r = {r, "0"};
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input string act, input string exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %s expected %s at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #2 tick = 1'b1;
      @(posedge clk); #2 tick = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  end

  always @(negedge clk) begin
    string exp;
    if (!rst) got = "";
    else begin
      if (busy && tick) got = {got, key_out ? "1" : "0"};
      if (!busy) check(key_out == 1'b0, "idle_key", $sformatf("%0d", key_out), "0");
      if (char_done || err) begin
        if (sb.size() == 0) check(1'b0, "unexpected_done", $sformatf("done=%0d err=%0d", char_done, err), "none");
        else begin
          exp = sb.pop_front();
          if (err) check(exp == "ERR" && got == "", "err_pulse", {"err units=", got}, exp);
          else check(got == exp, "char_units", got, exp);
        end
        got = "";
      end
    end
  end

  task automatic send(input logic [5:0] code);
    sb.push_back(model(code));
    @(posedge clk); #2 char_valid = 1'b1; char_code = code;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (char_ready) break;
      if (n > 500) begin
        check(1'b0, "handshake_timeout", "0", "1");
        break;
      end
    end
    @(posedge clk); #2 char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
      if (n > 2000) begin
        check(1'b0, "idle_timeout", $sformatf("pending=%0d", sb.size()), "0");
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check(key_out == 1'b0, "rst_key", $sformatf("%0d", key_out), "0");
    check(busy == 1'b0, "rst_busy", $sformatf("%0d", busy), "0");
    check(char_done == 1'b0 && err == 1'b0, "rst_pulses", $sformatf("%0d%0d", char_done, err), "00");
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check(char_ready == 1'b1, "ready_after_rst", $sformatf("%0d", char_ready), "1");
    send(6'd4);  wait_idle();
    send(6'd0);  wait_idle();
    send(6'd26); wait_idle();
    send(6'd40);
    @(negedge clk);
    check(err == 1'b1 && char_ready == 1'b1 && key_out == 1'b0, "illegal_cycle",
      $sformatf("err=%0d rdy=%0d key=%0d", err, char_ready, key_out), "err=1 rdy=1 key=0");
    @(negedge clk);
    check(err == 1'b0 && char_ready == 1'b1, "illegal_after", $sformatf("err=%0d rdy=%0d", err, char_ready), "err=0 rdy=1");
    wait_idle();
    send(6'd4);
    sb.push_back(model(36));
    char_valid = 1'b1; char_code = 6'd36;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (char_done) begin
        check(char_ready == 1'b1 && char_valid == 1'b1, "held_take", $sformatf("%0d", char_ready), "1");
        break;
      end
      if (busy == 1'b0 || n > 500) begin
        check(1'b0, "held_ignored", $sformatf("busy=%0d", busy), "busy until char_done");
        break;
      end
    end
    @(posedge clk); #2 char_valid = 1'b0;
    @(negedge clk);
    check(busy == 1'b1 && key_out == 1'b0, "wgap_start", $sformatf("busy=%0d key=%0d", busy, key_out), "busy=1 key=0");
    wait_idle();
    send(6'd19);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (busy && tick) break;
      if (n > 200) begin
        check(1'b0, "dash_tick_timeout", "0", "1");
        break;
      end
    end
    @(posedge clk); #3 rst = 1'b0;
    #1 check(key_out == 1'b0 && busy == 1'b0, "rst_mid_dash", $sformatf("key=%0d busy=%0d", key_out, busy), "key=0 busy=0");
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check(char_ready == 1'b1 && key_out == 1'b0, "idle_after_rst", $sformatf("rdy=%0d key=%0d", char_ready, key_out), "rdy=1 key=0");
    send(6'd4); wait_idle();
    repeat (30) begin
      send(6'($urandom_range(0, 45)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
